// File: rtl/cv32e40p_aligner_fifo.sv
// cv32e40p_aligner_fifo
//
// Instruction aligner with an internal halfword queue. It sits between the
// prefetch buffer and the ID stage. It accepts 32-bit fetch words and
// re-aligns mixed 16/32-bit RISC-V instructions that may start on any
// halfword boundary. The queue holds DEPTH words of skid, so fetch is not
// stalled while the decoder is busy. Fetch bus errors travel with each
// halfword and reach the decoder.
//
// Optional feature macro: CV32E40P_ALIGNER_HWLP_EN
//   Defined   - hardware-loop redirects (hwlp_update_pc_i / hwlp_addr_i) are
//               honoured, with a pending register when no pop is in progress.
//   Undefined - the hwlp ports are present but ignored.
//
// Parameters
//   DEPTH  queue capacity in 32-bit words (2..8, power of two)
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   fetch_valid_i       fetch word valid
//   fetch_ready_o       aligner can accept a fetch word (registers only)
//   fetch_rdata_i       fetch word, little-endian halfwords
//   fetch_err_i         bus error on this fetch word
//   instr_valid_o       complete instruction (or error) at the queue head
//   instr_ready_i       ID consumes the instruction
//   instr_aligned_o     aligned instruction, [31:16] don't-care if compressed
//   instr_compressed_o  head instruction is 16-bit
//   instr_err_o         a halfword of the head instruction carried an error
//   pc_o                PC of the head instruction
//   branch_i            redirect (branch/jump/exception); flushes the queue
//   branch_addr_i       redirect target, bit 0 ignored
//   hwlp_update_pc_i    hardware-loop jump on the current pop
//   hwlp_addr_i         hardware-loop target

module cv32e40p_aligner_fifo #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_valid_i,
  output logic        fetch_ready_o,
  input  logic [31:0] fetch_rdata_i,
  input  logic        fetch_err_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_aligned_o,
  output logic        instr_compressed_o,
  output logic        instr_err_o,
  output logic [31:0] pc_o,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  input  logic        hwlp_update_pc_i,
  input  logic [31:0] hwlp_addr_i
);

  localparam int N  = 2 * DEPTH;
  localparam int AW = $clog2(N);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_TWO  = CW'(2);
  localparam logic [CW-1:0] FULL_THR = CW'(N - 2);

  logic [15:0]   data_q [N];
  logic [N-1:0]  err_q;
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [CW-1:0] count_q;
  logic          skip_lo_q;
  logic [31:0]   pc_q;

  logic [AW-1:0] wptr_n1;
  logic [AW-1:0] rptr_n1;
  logic [15:0]   h0_data;
  logic [15:0]   h1_data;
  logic          h0_err;
  logic          h1_err;
  logic          have_one;
  logic          have_two;
  logic          compressed;
  logic          push;
  logic          pop;
  logic [CW-1:0] push_cnt;
  logic [CW-1:0] pop_cnt;
  logic [31:0]   branch_pc;
  logic          hwlp_take;
  logic [31:0]   hwlp_pc;

  assign wptr_n1 = wptr_q + 1'b1;
  assign rptr_n1 = rptr_q + 1'b1;

  assign h0_data = data_q[rptr_q];
  assign h1_data = data_q[rptr_n1];
  assign h0_err  = err_q[rptr_q];
  assign h1_err  = err_q[rptr_n1];

  assign have_one   = (count_q >= CNT_ONE);
  assign have_two   = (count_q >= CNT_TWO);
  assign compressed = (h0_data[1:0] != 2'b11);

  // Space check uses only the registered count, so a pop never reaches
  // fetch_ready_o combinationally.
  assign fetch_ready_o = (count_q <= FULL_THR);

  // Head outputs come from storage and count only, never from fetch inputs.
  // Error and compressed flags are qualified with a non-empty queue so stale
  // storage left behind by a flush cannot show through; this also keeps
  // instr_compressed_o low out of reset.
  assign instr_valid_o      = (have_one && compressed) || have_two || (have_one && h0_err);
  assign instr_aligned_o    = have_two ? {h1_data, h0_data} : {16'h0000, h0_data};
  assign instr_err_o        = have_one && (h0_err || (!compressed && have_two && h1_err));
  assign instr_compressed_o = have_one && compressed && !h0_err;
  assign pc_o               = pc_q;

  // An erroneous head is never popped; it waits for a redirect.
  assign push = fetch_valid_i && fetch_ready_o;
  assign pop  = instr_valid_o && instr_ready_i && !instr_err_o;

  assign branch_pc = {branch_addr_i[31:1], 1'b0};

  always_comb begin
    push_cnt = '0;
    pop_cnt  = '0;
    if (push) begin
      push_cnt = skip_lo_q ? CNT_ONE : CNT_TWO;
    end
    if (pop) begin
      pop_cnt = compressed ? CNT_ONE : CNT_TWO;
    end
  end

`ifdef CV32E40P_ALIGNER_HWLP_EN
  logic        hwlp_pending_q;
  logic [31:0] hwlp_addr_q;
  logic        unused_bits;

  // A request in the pop cycle takes effect at once; otherwise the
  // registered target is applied on the next pop.
  assign hwlp_take   = pop && (hwlp_update_pc_i || hwlp_pending_q);
  assign hwlp_pc     = hwlp_update_pc_i ? {hwlp_addr_i[31:1], 1'b0} : hwlp_addr_q;
  assign unused_bits = ^{hwlp_addr_i[0], branch_addr_i[0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hwlp_pending_q <= 1'b0;
      hwlp_addr_q    <= 32'h0;
    end else if (branch_i || hwlp_take) begin
      hwlp_pending_q <= 1'b0;
    end else if (hwlp_update_pc_i) begin
      hwlp_pending_q <= 1'b1;
      hwlp_addr_q    <= {hwlp_addr_i[31:1], 1'b0};
    end
  end
`else
  logic unused_bits;

  assign hwlp_take   = 1'b0;
  assign hwlp_pc     = 32'h0;
  assign unused_bits = ^{hwlp_update_pc_i, hwlp_addr_i, branch_addr_i[0]};
`endif

  // Queue state. A redirect (branch or hardware loop) wins over any push or
  // pop in the same cycle; skip_lo drops the low halfword of the first word
  // after a redirect to an odd-halfword address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        data_q[i] <= 16'h0000;
      end
      err_q     <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      skip_lo_q <= 1'b0;
      pc_q      <= 32'h0;
    end else if (branch_i) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      skip_lo_q <= branch_pc[1];
      pc_q      <= branch_pc;
    end else if (hwlp_take) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      skip_lo_q <= hwlp_pc[1];
      pc_q      <= hwlp_pc;
    end else begin
      if (push) begin
        if (skip_lo_q) begin
          data_q[wptr_q] <= fetch_rdata_i[31:16];
          err_q[wptr_q]  <= fetch_err_i;
          wptr_q         <= wptr_n1;
          skip_lo_q      <= 1'b0;
        end else begin
          data_q[wptr_q]  <= fetch_rdata_i[15:0];
          err_q[wptr_q]   <= fetch_err_i;
          data_q[wptr_n1] <= fetch_rdata_i[31:16];
          err_q[wptr_n1]  <= fetch_err_i;
          wptr_q          <= wptr_q + AW'(2);
        end
      end
      if (pop) begin
        rptr_q <= compressed ? rptr_n1 : rptr_q + AW'(2);
        pc_q   <= compressed ? pc_q + 32'd2 : pc_q + 32'd4;
      end
      count_q <= count_q + push_cnt - pop_cnt;
    end
  end

endmodule

// File: tb/tb_cv32e40p_aligner_fifo.sv
// tb_cv32e40p_aligner_fifo
//
// Self-checking bench for cv32e40p_aligner_fifo (DEPTH=2). Directed stimulus
// pushes hand-computed expected instructions into a scoreboard queue; an
// independent monitor compares the head whenever the DUT presents an
// instruction that the bench is accepting.

module tb_cv32e40p_aligner_fifo;

  logic        clk;
  logic        rst_n;
  logic        fetch_valid_i;
  logic        fetch_ready_o;
  logic [31:0] fetch_rdata_i;
  logic        fetch_err_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_aligned_o;
  logic        instr_compressed_o;
  logic        instr_err_o;
  logic [31:0] pc_o;
  logic        branch_i;
  logic [31:0] branch_addr_i;
  logic        hwlp_update_pc_i;
  logic [31:0] hwlp_addr_i;

  typedef struct {
    logic [31:0] instr;
    logic        comp;
    logic        err;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  cv32e40p_aligner_fifo #(.DEPTH(2)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .fetch_valid_i      (fetch_valid_i),
    .fetch_ready_o      (fetch_ready_o),
    .fetch_rdata_i      (fetch_rdata_i),
    .fetch_err_i        (fetch_err_i),
    .instr_valid_o      (instr_valid_o),
    .instr_ready_i      (instr_ready_i),
    .instr_aligned_o    (instr_aligned_o),
    .instr_compressed_o (instr_compressed_o),
    .instr_err_o        (instr_err_o),
    .pc_o               (pc_o),
    .branch_i           (branch_i),
    .branch_addr_i      (branch_addr_i),
    .hwlp_update_pc_i   (hwlp_update_pc_i),
    .hwlp_addr_i        (hwlp_addr_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  // Compares the presented head against one scoreboard entry; the upper
  // halfword is only meaningful for 32-bit instructions.
  task automatic checkOutput(input exp_t e);
    logic [31:0] mask;
    mask = e.comp ? 32'h0000FFFF : 32'hFFFFFFFF;
    checks++;
    if (((instr_aligned_o & mask) !== (e.instr & mask)) || (instr_compressed_o !== e.comp) ||
        (instr_err_o !== e.err) || (pc_o !== e.pc)) begin
      failures++;
      $display("[TB] FAIL head_pc_%h: got instr=%h c=%b e=%b pc=%h, expected instr=%h c=%b e=%b pc=%h",
               e.pc, instr_aligned_o, instr_compressed_o, instr_err_o, pc_o,
               e.instr, e.comp, e.err, e.pc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && instr_valid_o && instr_ready_i && !branch_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_instr: got instr=%h pc=%h, expected no instruction",
                 instr_aligned_o, pc_o);
      end else begin
        checkOutput(exp_q[0]);
        if (!exp_q[0].err) begin
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic expect_instr(input logic [31:0] instr, input logic comp, input logic err,
                              input logic [31:0] pc);
    exp_t e;
    e.instr = instr;
    e.comp  = comp;
    e.err   = err;
    e.pc    = pc;
    exp_q.push_back(e);
  endtask

  // Offers one fetch word until accepted. Called and returns at posedge+1.
  task automatic applyStimulus(input logic [31:0] word, input logic err);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    fetch_valid_i = 1'b1;
    fetch_rdata_i = word;
    fetch_err_i   = err;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = fetch_ready_o;
      step();
      n++;
    end
    fetch_valid_i = 1'b0;
    fetch_err_i   = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("[TB] FAIL push_timeout: got no accept for %h, expected accept within 100 cycles", word);
    end
  endtask

  task automatic doBranch(input logic [31:0] addr);
    branch_i      = 1'b1;
    branch_addr_i = addr;
    step();
    branch_i = 1'b0;
    @(negedge clk);
    checkValue("branch_valid", {31'b0, instr_valid_o}, 32'h0);
    checkValue("branch_pc", pc_o, {addr[31:1], 1'b0});
    step();
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    checkValue(name, exp_q.size(), 32'h0);
    exp_q.delete();
  endtask

  initial begin
    rst_n            = 1'b0;
    fetch_valid_i    = 1'b0;
    fetch_rdata_i    = 32'h0;
    fetch_err_i      = 1'b0;
    instr_ready_i    = 1'b1;
    branch_i         = 1'b0;
    branch_addr_i    = 32'h0;
    hwlp_update_pc_i = 1'b0;
    hwlp_addr_i      = 32'h0;

    repeat (2) @(negedge clk);
    checkValue("rst_valid", {31'b0, instr_valid_o}, 32'h0);
    checkValue("rst_fetch_ready", {31'b0, fetch_ready_o}, 32'h1);
    checkValue("rst_pc", pc_o, 32'h0);
    checkValue("rst_aligned", instr_aligned_o, 32'h0);
    checkValue("rst_compressed", {31'b0, instr_compressed_o}, 32'h0);
    checkValue("rst_err", {31'b0, instr_err_o}, 32'h0);
    step();
    rst_n = 1'b1;
    step();

    $display("[TB] aligned stream");
    expect_instr(32'h00000013, 1'b0, 1'b0, 32'h0);
    expect_instr(32'h00A00093, 1'b0, 1'b0, 32'h4);
    applyStimulus(32'h00000013, 1'b0);
    applyStimulus(32'h00A00093, 1'b0);
    waitDrain("aligned_drain");

    $display("[TB] mixed stream");
    doBranch(32'h0);
    expect_instr(32'h00004505, 1'b1, 1'b0, 32'h0);
    expect_instr(32'h00010013, 1'b0, 1'b0, 32'h2);
    expect_instr(32'h00000001, 1'b1, 1'b0, 32'h6);
    applyStimulus(32'h00134505, 1'b0);
    applyStimulus(32'h00010001, 1'b0);
    waitDrain("mixed_drain");

    $display("[TB] misaligned branch");
    doBranch(32'h102);
    expect_instr(32'h00004505, 1'b1, 1'b0, 32'h102);
    applyStimulus(32'h4505FFFF, 1'b0);
    waitDrain("misaligned_drain");
    @(negedge clk);
    checkValue("misaligned_empty", {31'b0, instr_valid_o}, 32'h0);
    step();

    $display("[TB] backpressure and wrap");
    doBranch(32'h1000);
    instr_ready_i = 1'b0;
    expect_instr(32'h00100093, 1'b0, 1'b0, 32'h1000);
    expect_instr(32'h00200113, 1'b0, 1'b0, 32'h1004);
    expect_instr(32'h00300193, 1'b0, 1'b0, 32'h1008);
    expect_instr(32'h00400213, 1'b0, 1'b0, 32'h100C);
    fetch_valid_i = 1'b1;
    fetch_rdata_i = 32'h00100093;
    @(negedge clk);
    checkValue("bp_ready_w0", {31'b0, fetch_ready_o}, 32'h1);
    step();
    fetch_rdata_i = 32'h00200113;
    @(negedge clk);
    checkValue("bp_ready_w1", {31'b0, fetch_ready_o}, 32'h1);
    step();
    fetch_rdata_i = 32'h00300193;
    @(negedge clk);
    checkValue("bp_full", {31'b0, fetch_ready_o}, 32'h0);
    step();
    instr_ready_i = 1'b1;
    @(negedge clk);
    checkValue("bp_full_hold", {31'b0, fetch_ready_o}, 32'h0);
    step();
    instr_ready_i = 1'b0;
    @(negedge clk);
    checkValue("bp_freed", {31'b0, fetch_ready_o}, 32'h1);
    step();
    instr_ready_i = 1'b1;
    applyStimulus(32'h00400213, 1'b0);
    waitDrain("bp_drain");

    $display("[TB] fetch error hold");
    doBranch(32'h0);
    expect_instr(32'h00004505, 1'b1, 1'b0, 32'h0);
    expect_instr(32'h00010013, 1'b0, 1'b1, 32'h2);
    applyStimulus(32'h00134505, 1'b0);
    applyStimulus(32'h00010001, 1'b1);
    repeat (4) step();
    @(negedge clk);
    checkValue("err_valid", {31'b0, instr_valid_o}, 32'h1);
    checkValue("err_flag", {31'b0, instr_err_o}, 32'h1);
    checkValue("err_pc_held", pc_o, 32'h2);
    checkValue("err_entries_left", exp_q.size(), 32'h1);
    step();
    exp_q.delete();
    doBranch(32'h40);

    $display("[TB] hardware loop");
    doBranch(32'h0);
    instr_ready_i = 1'b0;
    expect_instr(32'h00000013, 1'b0, 1'b0, 32'h0);
`ifndef CV32E40P_ALIGNER_HWLP_EN
    expect_instr(32'h00A00093, 1'b0, 1'b0, 32'h4);
`endif
    applyStimulus(32'h00000013, 1'b0);
    applyStimulus(32'h00A00093, 1'b0);
    hwlp_update_pc_i = 1'b1;
    hwlp_addr_i      = 32'h200;
    step();
    hwlp_update_pc_i = 1'b0;
    instr_ready_i    = 1'b1;
    step();
    @(negedge clk);
`ifdef CV32E40P_ALIGNER_HWLP_EN
    checkValue("hwlp_pc", pc_o, 32'h200);
    checkValue("hwlp_flushed", {31'b0, instr_valid_o}, 32'h0);
`else
    checkValue("hwlp_ignored_pc", pc_o, 32'h4);
    checkValue("hwlp_ignored_valid", {31'b0, instr_valid_o}, 32'h1);
`endif
    step();
    waitDrain("hwlp_drain");

    $display("[TB] asynchronous reset");
    doBranch(32'h300);
    instr_ready_i = 1'b0;
    applyStimulus(32'h00000013, 1'b0);
    @(negedge clk);
    checkValue("pre_reset_valid", {31'b0, instr_valid_o}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    checkValue("async_rst_valid", {31'b0, instr_valid_o}, 32'h0);
    checkValue("async_rst_pc", pc_o, 32'h0);
    checkValue("async_rst_ready", {31'b0, fetch_ready_o}, 32'h1);
    step();
    rst_n = 1'b1;
    step();

    checkValue("scoreboard_empty", exp_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cv32e40p_aligner_fifo.md
# cv32e40p_aligner_fifo

Parametrised instruction aligner with an internal halfword queue. It sits between the prefetch buffer and the ID stage, accepts 32-bit fetch words, and re-aligns mixed 16/32-bit RISC-V instructions at any halfword boundary. It uses a decoupled valid/ready handshake on both sides and tracks the PC of the presented instruction. Unlike the single-register aligner, it absorbs DEPTH words of skid without stalling fetch and carries fetch bus errors through to the decoder.

## Interface
- DEPTH, 2: queue capacity in 32-bit words (2*DEPTH halfword entries); legal range 2..8, power of two.
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- fetch_valid_i  input  1  fetch word valid
- fetch_ready_o  output  1  aligner can accept a fetch word
- fetch_rdata_i  input  32  fetch word, little-endian halfwords
- fetch_err_i  input  1  bus error on this fetch word
- instr_valid_o  output  1  complete instruction at queue head
- instr_ready_i  input  1  ID consumes the instruction
- instr_aligned_o  output  32  instruction; bits [31:16] are don't-care when compressed
- instr_compressed_o  output  1  head instruction is 16-bit
- instr_err_o  output  1  a halfword of the head instruction carried fetch_err_i
- pc_o  output  32  PC of the head instruction
- branch_i  input  1  redirect (branch/jump/exception)
- branch_addr_i  input  32  redirect target; bit 0 is ignored
- hwlp_update_pc_i  input  1  hardware-loop jump on the current pop
- hwlp_addr_i  input  32  hardware-loop target

## Operation
- Storage: circular array of 2*DEPTH entries, each {err, 16-bit data}. Write pointer and read pointer are $clog2(2*DEPTH) bits and wrap modulo 2*DEPTH. Occupancy count is $clog2(2*DEPTH)+1 bits.
- Push, on fetch_valid_i && fetch_ready_o:
  - Normal: write both halfwords, low halfword first; count increases by 2.
  - When skip_lo=1: write only [31:16]; count increases by 1; skip_lo clears.
- fetch_ready_o = (count <= 2*DEPTH-2). It is derived from registers only.
- Head decode: h0 is the entry at the read pointer; h1 is the next entry.
  - compressed = h0[1:0] != 2'b11.
  - instr_valid_o = (count>=1 && compressed) || count>=2 || (count>=1 && h0.err).
  - instr_aligned_o = {h1, h0} when count>=2, otherwise {16'h0, h0}.
  - instr_err_o = h0.err || (!compressed && count>=2 && h1.err).
  - instr_compressed_o = compressed && !h0.err.
- Pop, on instr_valid_o && instr_ready_i && !instr_err_o: advance 1 entry (compressed) or 2 entries; pc_q += 2 or 4, modulo 2^32.
- Error hold: while instr_err_o=1, pops are ignored and the head stays presented until branch_i. Pushes continue while space is available.
- Redirect, branch_i:
  - Next state: count=0, both pointers=0, pc_q=branch_addr_i, skip_lo=branch_addr_i[1].
  - Any push or pop in the same cycle is discarded.
- Push and pop in the same cycle are allowed; the net count change is push minus pop.
- A push is never accepted when count > 2*DEPTH-2, so overflow is impossible by construction.
- A pop with insufficient entries is impossible because instr_valid_o already gates it.

## Timing
- Reset values: count=0, pointers=0, skip_lo=0, pc_q=0, storage=0. Resulting outputs: instr_valid_o=0, fetch_ready_o=1, pc_o=0, instr_aligned_o=0, instr_compressed_o=0, instr_err_o=0.
- No combinational path from fetch inputs to instr_* outputs. A word pushed in cycle N is visible at the head in cycle N+1 at the earliest.
- No combinational path from instr_ready_i to fetch_ready_o. Space freed by a pop in cycle N is visible in cycle N+1.
- After branch_i in cycle N: instr_valid_o=0 and pc_o=target in cycle N+1. The first target instruction appears at N+2 at the earliest.
- Reset asserted mid-operation clears all state asynchronously. A pending hardware-loop target is also cleared.

## Configuration
- CV32E40P_ALIGNER_HWLP_EN defined: hardware-loop redirects are supported.
  - hwlp_update_pc_i in a pop cycle: pc_q=hwlp_addr_i, remaining entries are flushed (count=0), skip_lo=hwlp_addr_i[1]; the push in that cycle is discarded.
  - hwlp_update_pc_i without a pop: hwlp_addr_i and a pending flag are registered and applied at the next pop.
  - branch_i clears the pending flag.
- CV32E40P_ALIGNER_HWLP_EN undefined: the ports remain; hwlp_update_pc_i and hwlp_addr_i are ignored and no pending registers are synthesised.

## Test plan
- Aligned stream: push 0x00000013, 0x00A00093 with instr_ready_i=1 -> two 32-bit pops, pc_o sequence 0, 4; compressed=0.
- Mixed stream: push 0x00134505, 0x0001_0001 -> instr 0x4505 (pc 0, compressed), then 0x00010013 spanning the word boundary (pc 2, 32-bit), then 0x0001 (pc 6).
- Misaligned branch: branch_i with branch_addr_i=0x102, then push 0x4505_FFFF -> low half dropped, instr 0x4505 at pc 0x102, count returns to 0.
- Backpressure: DEPTH=2, instr_ready_i=0, offer 4 words -> exactly 2 accepted, fetch_ready_o=0 from the cycle after the 2nd push; one 32-bit pop -> fetch_ready_o=1 next cycle; pointers wrap without data corruption.
- Error: push a 32-bit instruction whose upper-half word has fetch_err_i=1 -> instr_valid_o=1, instr_err_o=1, held despite instr_ready_i=1 until branch_i flushes.
- HWLP (macro on): hwlp_update_pc_i=1, hwlp_addr_i=0x200 one cycle before a pop -> after the pop pc_o=0x200, count=0.
